// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS-subset controller.
// master = control FSM, slave = datapath side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic             mem_re;
    logic             mem_we;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
               alu_src, alu_op, mem_re, mem_we, halted, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
               alu_src, alu_op, mem_re, mem_we, halted, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences PC, IR, regfile, ALU and data memory,
// halts on illegal instructions and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctrl_if
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       legal_c;
    logic [2:0] r_alu_op_c;
    logic       ir_we_c, pc_we_c, reg_we_c, alu_src_c, mem_re_c, mem_we_c, halted_c;
    logic [1:0] pc_src_c, reg_dst_c, mem_to_reg_c;
    logic [2:0] alu_op_c;
    logic       retire_c;

    // Legal-instruction decode and R-type funct to ALU command mapping
    always_comb begin
        legal_c    = 1'b0;
        r_alu_op_c = ALU_ADD;
        case (ctrl_if.opcode)
            OP_RTYPE: legal_c = (ctrl_if.funct == FN_ADD) || (ctrl_if.funct == FN_SUB) ||
                                (ctrl_if.funct == FN_SLT) || (ctrl_if.funct == FN_JR);
            OP_J, OP_JAL, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
        case (ctrl_if.funct)
            FN_SUB:  r_alu_op_c = ALU_SUB;
            FN_SLT:  r_alu_op_c = ALU_SLT;
            default: r_alu_op_c = ALU_ADD;
        endcase
    end

    // Next-state, datapath controls and retire counter update
    always_comb begin
        state_d      = state_q;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        reg_we_c     = 1'b0;
        reg_dst_c    = 2'd0;
        mem_to_reg_c = 2'd0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALU_ADD;
        mem_re_c     = 1'b0;
        mem_we_c     = 1'b0;
        halted_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ctrl_if.opcode == OP_J || ctrl_if.opcode == OP_JAL) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = 2'd2;
                    if (ctrl_if.opcode == OP_JAL) begin
                        reg_we_c     = 1'b1;
                        reg_dst_c    = 2'd2;
                        mem_to_reg_c = 2'd2;
                    end
                    state_d = S_FETCH;
                end else if (legal_c) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                case (ctrl_if.opcode)
                    OP_RTYPE: begin
                        if (ctrl_if.funct == FN_JR) begin
                            pc_we_c  = 1'b1;
                            pc_src_c = 2'd3;
                            state_d  = S_FETCH;
                        end else begin
                            alu_op_c = r_alu_op_c;
                            state_d  = S_WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_src_c = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_XORI: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALU_XOR;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BNE: begin
                        alu_op_c = ALU_SUB;
                        pc_src_c = 2'd1;
                        pc_we_c  = ~ctrl_if.zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                // address operands held so the memory sees a stable address
                alu_src_c = 1'b1;
                mem_re_c  = (ctrl_if.opcode == OP_LW);
                mem_we_c  = (ctrl_if.opcode == OP_SW);
                if (ctrl_if.mem_ready) begin
                    state_d = (ctrl_if.opcode == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                state_d  = S_FETCH;
                case (ctrl_if.opcode)
                    OP_RTYPE: begin
                        reg_dst_c = 2'd1;
                        alu_op_c  = r_alu_op_c;
                    end
                    OP_ADDI: alu_src_c = 1'b1;
                    OP_XORI: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALU_XOR;
                    end
                    OP_LW:   mem_to_reg_c = 2'd1;
                    default: mem_to_reg_c = 2'd0;
                endcase
            end
            S_HALT: halted_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        retire_c = (state_q != S_FETCH) && (state_d == S_FETCH);
        cnt_d    = cnt_q + CNT_W'(retire_c);
    end

    // State and retired-instruction counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enables are forced low while reset is held
    assign ctrl_if.ir_we       = ir_we_c  & rst_n;
    assign ctrl_if.pc_we       = pc_we_c  & rst_n;
    assign ctrl_if.reg_we      = reg_we_c & rst_n;
    assign ctrl_if.mem_re      = mem_re_c & rst_n;
    assign ctrl_if.mem_we      = mem_we_c & rst_n;
    assign ctrl_if.pc_src      = pc_src_c;
    assign ctrl_if.reg_dst     = reg_dst_c;
    assign ctrl_if.mem_to_reg  = mem_to_reg_c;
    assign ctrl_if.alu_src     = alu_src_c;
    assign ctrl_if.alu_op      = alu_op_c;
    assign ctrl_if.halted      = halted_c;
    assign ctrl_if.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.CNT_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 32'd0;

    // Per-cycle stimulus and expected control vector
    logic [5:0]  q_op[$];
    logic [5:0]  q_fn[$];
    logic        q_mr[$];
    logic        q_z[$];
    logic [15:0] q_ev[$];

    logic [15:0] vF, vZ, vH;

    function automatic logic [15:0] v(int ir, int pw, int ps, int rw, int rd, int m2,
                                      int as, int ao, int re, int we, int h);
        return {1'(ir), 1'(pw), 2'(ps), 1'(rw), 2'(rd), 2'(m2),
                1'(as), 3'(ao), 1'(re), 1'(we), 1'(h)};
    endfunction

    function automatic logic [15:0] ctl();
        return {bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src, bus.alu_op, bus.mem_re, bus.mem_we, bus.halted};
    endfunction

    task automatic clear_q();
        q_op.delete(); q_fn.delete(); q_mr.delete(); q_z.delete(); q_ev.delete();
    endtask

    task automatic push(input int op, input int fn, input int mr, input int z, input logic [15:0] ev);
        q_op.push_back(6'(op));
        q_fn.push_back(6'(fn));
        q_mr.push_back(1'(mr));
        q_z.push_back(1'(z));
        q_ev.push_back(ev);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ctl() !== 16'h0) begin
            n_fail++; $display("FAIL reset_ctl got %h expected %h", ctl(), 16'h0);
        end
        n_checks++;
        if (bus.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count got %0d expected 0", bus.instr_count);
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctl() !== vF) begin
            n_fail++; $display("FAIL reset_release_fetch got %h expected %h", ctl(), vF);
        end
    endtask

    task automatic test_alu_ops();
        clear_q();
        // ADD
        push(8'h00, 8'h20, 0, 0, vF); push(8'h00, 8'h20, 0, 0, vZ);
        push(8'h00, 8'h20, 0, 0, vZ); push(8'h00, 8'h20, 0, 0, v(0,0,0,1,1,0,0,0,0,0,0));
        // SUB
        push(8'h00, 8'h22, 0, 0, vF); push(8'h00, 8'h22, 0, 0, vZ);
        push(8'h00, 8'h22, 0, 0, v(0,0,0,0,0,0,0,1,0,0,0));
        push(8'h00, 8'h22, 0, 0, v(0,0,0,1,1,0,0,1,0,0,0));
        // SLT
        push(8'h00, 8'h2A, 0, 0, vF); push(8'h00, 8'h2A, 0, 0, vZ);
        push(8'h00, 8'h2A, 0, 0, v(0,0,0,0,0,0,0,3,0,0,0));
        push(8'h00, 8'h2A, 0, 0, v(0,0,0,1,1,0,0,3,0,0,0));
        // JR
        push(8'h00, 8'h08, 0, 0, vF); push(8'h00, 8'h08, 0, 0, vZ);
        push(8'h00, 8'h08, 0, 0, v(0,1,3,0,0,0,0,0,0,0,0));
        // ADDI
        push(8'h08, 8'h20, 0, 0, vF); push(8'h08, 8'h20, 0, 0, vZ);
        push(8'h08, 8'h20, 0, 0, v(0,0,0,0,0,0,1,0,0,0,0));
        push(8'h08, 8'h20, 0, 0, v(0,0,0,1,0,0,1,0,0,0,0));
        // XORI
        push(8'h0E, 8'h20, 0, 0, vF); push(8'h0E, 8'h20, 0, 0, vZ);
        push(8'h0E, 8'h20, 0, 0, v(0,0,0,0,0,0,1,2,0,0,0));
        push(8'h0E, 8'h20, 0, 0, v(0,0,0,1,0,0,1,2,0,0,0));
        foreach (q_ev[k]) begin
            bus.opcode = q_op[k]; bus.funct = q_fn[k]; bus.mem_ready = q_mr[k]; bus.zero = q_z[k];
            if (k > 0 && q_ev[k][15]) exp_cnt++;
            #1;
            n_checks++;
            if (ctl() !== q_ev[k]) begin
                n_fail++; $display("FAIL alu_ops cyc%0d ctl got %h expected %h", k, ctl(), q_ev[k]);
            end
            n_checks++;
            if (bus.instr_count !== exp_cnt) begin
                n_fail++; $display("FAIL alu_ops cyc%0d count got %0d expected %0d", k, bus.instr_count, exp_cnt);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (bus.instr_count !== exp_cnt) begin
            n_fail++; $display("FAIL alu_ops end count got %0d expected %0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_mem();
        clear_q();
        // LW with three wait cycles; mem_ready high in DECODE/EXEC must be ignored
        push(8'h23, 0, 0, 0, vF); push(8'h23, 0, 1, 0, vZ);
        push(8'h23, 0, 1, 0, v(0,0,0,0,0,0,1,0,0,0,0));
        push(8'h23, 0, 0, 0, v(0,0,0,0,0,0,1,0,1,0,0));
        push(8'h23, 0, 0, 0, v(0,0,0,0,0,0,1,0,1,0,0));
        push(8'h23, 0, 0, 0, v(0,0,0,0,0,0,1,0,1,0,0));
        push(8'h23, 0, 1, 0, v(0,0,0,0,0,0,1,0,1,0,0));
        push(8'h23, 0, 0, 0, v(0,0,0,1,0,1,0,0,0,0,0));
        // SW with no wait
        push(8'h2B, 0, 0, 0, vF); push(8'h2B, 0, 0, 0, vZ);
        push(8'h2B, 0, 0, 0, v(0,0,0,0,0,0,1,0,0,0,0));
        push(8'h2B, 0, 1, 0, v(0,0,0,0,0,0,1,0,0,1,0));
        foreach (q_ev[k]) begin
            bus.opcode = q_op[k]; bus.funct = q_fn[k]; bus.mem_ready = q_mr[k]; bus.zero = q_z[k];
            if (k > 0 && q_ev[k][15]) exp_cnt++;
            #1;
            n_checks++;
            if (ctl() !== q_ev[k]) begin
                n_fail++; $display("FAIL mem cyc%0d ctl got %h expected %h", k, ctl(), q_ev[k]);
            end
            n_checks++;
            if (bus.instr_count !== exp_cnt) begin
                n_fail++; $display("FAIL mem cyc%0d count got %0d expected %0d", k, bus.instr_count, exp_cnt);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (bus.instr_count !== exp_cnt) begin
            n_fail++; $display("FAIL mem end count got %0d expected %0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_branch_jump();
        clear_q();
        // BNE taken (zero=0) then not taken (zero=1)
        push(8'h05, 0, 0, 1, vF); push(8'h05, 0, 0, 1, vZ);
        push(8'h05, 0, 0, 0, v(0,1,1,0,0,0,0,1,0,0,0));
        push(8'h05, 0, 0, 0, vF); push(8'h05, 0, 0, 0, vZ);
        push(8'h05, 0, 0, 1, v(0,0,1,0,0,0,0,1,0,0,0));
        // J then JAL resolved in DECODE
        push(8'h02, 0, 0, 0, vF); push(8'h02, 0, 0, 0, v(0,1,2,0,0,0,0,0,0,0,0));
        push(8'h03, 0, 0, 0, vF); push(8'h03, 0, 0, 0, v(0,1,2,1,2,2,0,0,0,0,0));
        foreach (q_ev[k]) begin
            bus.opcode = q_op[k]; bus.funct = q_fn[k]; bus.mem_ready = q_mr[k]; bus.zero = q_z[k];
            if (k > 0 && q_ev[k][15]) exp_cnt++;
            #1;
            n_checks++;
            if (ctl() !== q_ev[k]) begin
                n_fail++; $display("FAIL branch_jump cyc%0d ctl got %h expected %h", k, ctl(), q_ev[k]);
            end
            n_checks++;
            if (bus.instr_count !== exp_cnt) begin
                n_fail++; $display("FAIL branch_jump cyc%0d count got %0d expected %0d", k, bus.instr_count, exp_cnt);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_checks++;
        if (bus.instr_count !== exp_cnt) begin
            n_fail++; $display("FAIL branch_jump end count got %0d expected %0d", bus.instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        for (int c = 0; c < 2; c++) begin
            int op, fn, nh;
            op = (c == 0) ? 8'h00 : 8'h3F;
            fn = (c == 0) ? 8'h21 : 8'h00;
            nh = (c == 0) ? 3 : 20;
            clear_q();
            push(op, fn, 0, 0, vF); push(op, fn, 0, 0, vZ);
            for (int h = 0; h < nh; h++) push(op, fn, h % 2, 0, vH);
            foreach (q_ev[k]) begin
                bus.opcode = q_op[k]; bus.funct = q_fn[k]; bus.mem_ready = q_mr[k]; bus.zero = q_z[k];
                #1;
                n_checks++;
                if (ctl() !== q_ev[k]) begin
                    n_fail++; $display("FAIL illegal%0d cyc%0d ctl got %h expected %h", c, k, ctl(), q_ev[k]);
                end
                n_checks++;
                if (bus.instr_count !== exp_cnt) begin
                    n_fail++; $display("FAIL illegal%0d cyc%0d count got %0d expected %0d", c, k, bus.instr_count, exp_cnt);
                end
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            exp_cnt = 32'd0;
            #1;
            n_checks++;
            if (ctl() !== 16'h0) begin
                n_fail++; $display("FAIL illegal%0d reset_ctl got %h expected %h", c, ctl(), 16'h0);
            end
            n_checks++;
            if (bus.instr_count !== exp_cnt) begin
                n_fail++; $display("FAIL illegal%0d reset_count got %0d expected 0", c, bus.instr_count);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            n_checks++;
            if (ctl() !== vF) begin
                n_fail++; $display("FAIL illegal%0d restart got %h expected %h", c, ctl(), vF);
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [15:0] v_swm;
        v_swm = v(0,0,0,0,0,0,1,0,0,1,0);
        clear_q();
        push(8'h2B, 0, 0, 0, vF); push(8'h2B, 0, 0, 0, vZ);
        push(8'h2B, 0, 0, 0, v(0,0,0,0,0,0,1,0,0,0,0));
        push(8'h2B, 0, 0, 0, v_swm); push(8'h2B, 0, 0, 0, v_swm);
        foreach (q_ev[k]) begin
            bus.opcode = q_op[k]; bus.funct = q_fn[k]; bus.mem_ready = q_mr[k]; bus.zero = q_z[k];
            #1;
            n_checks++;
            if (ctl() !== q_ev[k]) begin
                n_fail++; $display("FAIL sw_reset cyc%0d ctl got %h expected %h", k, ctl(), q_ev[k]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ctl() !== v_swm) begin
            n_fail++; $display("FAIL sw_reset still_waiting got %h expected %h", ctl(), v_swm);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL sw_reset mem_we_drop got %b expected 0", bus.mem_we);
        end
        n_checks++;
        if (bus.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL sw_reset count got %0d expected 0", bus.instr_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctl() !== vF) begin
            n_fail++; $display("FAIL sw_reset restart got %h expected %h", ctl(), vF);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ctl() !== vZ || bus.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL sw_reset decode got %h cnt %0d expected %h cnt 0", ctl(), bus.instr_count, vZ);
        end
    endtask

    initial begin
        vF = v(1,1,0,0,0,0,0,0,0,0,0);
        vZ = 16'h0;
        vH = v(0,0,0,0,0,0,0,0,0,0,1);
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_sw_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
